mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255: max cycles in FETCH/MEM without mem_ready before fault.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 op/funct7/funct3  in  7/7/3  opcode, funct7, funct3 fields from the instruction register.
REQ-005 zero  in  1  ALU zero flag, sampled in EXEC.
REQ-006 mem_ready  in  1  memory completes current request this cycle.
REQ-007 mem_req/mem_we  out  1/1  memory request, write qualifier.
REQ-008 addr_sel  out  1  memory address source: 0 PC, 1 ALU result register.
REQ-009 ir_we/pc_we/reg_we  out  1/1/1  IR, PC, register-file write strobes.
REQ-010 npc_op  out  3  000 PLUS4, 001 BRANCH, 010 JUMP.
REQ-011 alu_op/alu_src/ext_op/wd_sel  out  5/1/6/2  same encodings as the single-cycle decoder (ctrl_encode_def).
REQ-012 state  out  3  current state; err  out  1  sticky fault flag.

Function
REQ-013 States: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=7; all outputs Moore from state plus registered instruction class.
REQ-014 RST -> FETCH unconditionally after one cycle; no strobe asserted in RST.
REQ-015 FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ready: ir_we=1 same cycle, -> DECODE.
REQ-016 DECODE (1 cycle): class latched (R, I-arith, LUI, LW, SW, BEQ, JAL); unsupported encoding -> ERR.
REQ-017 EXEC (1 cycle): alu_op/alu_src/ext_op valid; LW/SW -> MEM; R/I/LUI/JAL -> WB; BEQ -> FETCH with pc_we=1, npc_op=BRANCH if zero else PLUS4.
REQ-018 MEM: mem_req=1, addr_sel=1, mem_we=1 only for SW; on mem_ready: SW -> FETCH with pc_we=1 PLUS4; LW -> WB.
REQ-019 WB (1 cycle): reg_we=1, wd_sel ALU/MEM/PC per class; pc_we=1, npc_op=JUMP for JAL else PLUS4; -> FETCH.
REQ-020 pc_we SHALL pulse exactly once per retired instruction; reg_we never for SW/BEQ.
REQ-021 Handshake: mem_req, mem_we, addr_sel held constant from request until mem_ready cycle inclusive; mem_ready ignored outside FETCH/MEM.
REQ-022 Wait counter cleared on entry to FETCH/MEM, increments per non-ready cycle; reaching WAIT_MAX -> ERR; mem_ready on the WAIT_MAX cycle wins.
REQ-023 ERR: err=1, all strobes 0, held until reset.
REQ-024 Latency without wait states: BEQ 3, R/I/LUI/JAL 4, SW 4, LW 5 cycles.

Reset
REQ-025 rstn low: state=RST, err=0, wait counter=0, class=none, all strobes 0, asynchronously; reset mid-request abandons the access with no pc_we/reg_we.

Configuration
REQ-026 MC_CTRL_PERF_EN defined: outputs cycle_cnt[31:0] (+1 every cycle outside RST/ERR) and instret[31:0] (+1 per pc_we), both wrap at 2^32, reset to 0.
REQ-027 MC_CTRL_PERF_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-028 State encoding, instruction-class enum and NPC/WDSel/ALUOp/EXTOp constants in shared package mc_ctrl_pkg.
REQ-029 Combinational field decode in sub-module mc_decode (op/funct7/funct3 -> class, alu_op, ext_op, illegal); FSM and counters in mc_ctrl.

Verification
REQ-030 add (op=0110011,f7=0,f3=0), mem_ready=1 in fetch -> states 1,2,3,5,1; reg_we in WB, alu_op=00011, single pc_we PLUS4.
REQ-031 lw with 3 memory wait cycles in MEM -> mem_req/addr_sel=1 stable 4 cycles, WB wd_sel=01, total 8 cycles.
REQ-032 beq, zero=1 then zero=0 -> EXEC pc_we with npc_op=001 then 000, no reg_we.
REQ-033 WAIT_MAX=4, mem_ready never asserted -> ERR after 4 FETCH cycles, err=1 sticky; ready on 4th cycle -> DECODE.
REQ-034 op=1111111 -> ERR from DECODE; rstn pulse mid-MEM of sw -> RST, mem_req=0 immediately, err=0.
REQ-035 MC_CTRL_PERF_EN: 10 add instructions, no waits -> instret=10, cycle_cnt=40.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, instruction classes and datapath control encodings for
// the multi-cycle controller (mc_ctrl) and its field decoder (mc_decode).
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_R, CLS_I, CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_JAL
    } cls_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    localparam logic [4:0] ALU_NOP  = 5'b00000;
    localparam logic [4:0] ALU_LUI  = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_XOR  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_AND  = 5'b01110;
    localparam logic [4:0] ALU_SLL  = 5'b01111;
    localparam logic [4:0] ALU_SRL  = 5'b10000;
    localparam logic [4:0] ALU_SRA  = 5'b10001;

    localparam logic [5:0] EXT_NONE        = 6'b000000;
    localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_JTYPE       = 6'b000001;

    // alt selects SUB/SRA over ADD/SRL (funct7 bit 5 on R-type and shift-immediates)
    function automatic logic [4:0] arith_alu_op(input logic [2:0] f3, input logic alt);
        logic [4:0] res;
        res = ALU_NOP;
        case (f3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-field decode: op/funct7/funct3 to instruction class,
// ALU operation, immediate-extension select and illegal-encoding flag.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output cls_t       cls,
    output logic [4:0] alu_op,
    output logic [5:0] ext_op,
    output logic       alu_src,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_NONE;
        alu_op  = ALU_NOP;
        ext_op  = EXT_NONE;
        alu_src = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                cls     = CLS_R;
                alu_op  = arith_alu_op(funct3, funct7[5]);
                illegal = !(funct7 == F7_BASE ||
                            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OP_I: begin
                cls     = CLS_I;
                alu_src = 1'b1;
                // only the shift forms carry an encoding in funct7; elsewhere it is immediate
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    ext_op  = EXT_ITYPE_SHAMT;
                    alu_op  = arith_alu_op(funct3, funct7[5]);
                    illegal = (funct3 == 3'b001) ? (funct7 != F7_BASE)
                                                 : !(funct7 == F7_BASE || funct7 == F7_ALT);
                end else begin
                    ext_op = EXT_ITYPE;
                    alu_op = arith_alu_op(funct3, 1'b0);
                end
            end
            OP_LUI: begin
                cls     = CLS_LUI;
                alu_op  = ALU_LUI;
                ext_op  = EXT_UTYPE;
                alu_src = 1'b1;
            end
            OP_LW: begin
                cls     = CLS_LW;
                alu_op  = ALU_ADD;
                ext_op  = EXT_ITYPE;
                alu_src = 1'b1;
                illegal = (funct3 != 3'b010);
            end
            OP_SW: begin
                cls     = CLS_SW;
                alu_op  = ALU_ADD;
                ext_op  = EXT_STYPE;
                alu_src = 1'b1;
                illegal = (funct3 != 3'b010);
            end
            OP_BEQ: begin
                cls     = CLS_BEQ;
                alu_op  = ALU_SUB;
                ext_op  = EXT_BTYPE;
                illegal = (funct3 != 3'b000);
            end
            OP_JAL: begin
                cls    = CLS_JAL;
                ext_op = EXT_JTYPE;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) cls = CLS_NONE;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM with memory wait-state timeout and sticky error state.
// Optional performance counters (cycle_cnt, instret) when MC_CTRL_PERF_EN is defined.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [6:0] op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       reg_we,
    output logic [2:0] npc_op,
    output logic [4:0] alu_op,
    output logic       alu_src,
    output logic [5:0] ext_op,
    output logic [1:0] wd_sel,
    output logic [2:0] state,
    output logic       err
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
`endif
);

    localparam int WCW = $clog2(WAIT_MAX + 1);

    state_t           state_reg, state_next;
    cls_t             cls_reg;
    logic [4:0]       alu_op_reg;
    logic [5:0]       ext_op_reg;
    logic             alu_src_reg;
    logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic             wait_last;

    cls_t             dec_cls;
    logic [4:0]       dec_alu_op;
    logic [5:0]       dec_ext_op;
    logic             dec_alu_src;
    logic             dec_illegal;

    mc_decode u_decode (
        .op      (op),
        .funct7  (funct7),
        .funct3  (funct3),
        .cls     (dec_cls),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .alu_src (dec_alu_src),
        .illegal (dec_illegal)
    );

    assign wait_last = (wait_cnt_reg == WCW'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= ST_RST;
            wait_cnt_reg <= '0;
            cls_reg      <= CLS_NONE;
            alu_op_reg   <= ALU_NOP;
            ext_op_reg   <= EXT_NONE;
            alu_src_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_reg == ST_DECODE) begin
                cls_reg     <= dec_cls;
                alu_op_reg  <= dec_alu_op;
                ext_op_reg  <= dec_ext_op;
                alu_src_reg <= dec_alu_src;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        reg_we     = 1'b0;
        npc_op     = NPC_PLUS4;
        alu_op     = ALU_NOP;
        alu_src    = 1'b0;
        ext_op     = EXT_NONE;
        wd_sel     = WD_ALU;
        case (state_reg)
            ST_RST: state_next = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else if (wait_last) begin
                    state_next = ST_ERR;
                end
            end
            ST_DECODE: state_next = dec_illegal ? ST_ERR : ST_EXEC;
            ST_EXEC: begin
                alu_op  = alu_op_reg;
                alu_src = alu_src_reg;
                ext_op  = ext_op_reg;
                case (cls_reg)
                    CLS_LW, CLS_SW: state_next = ST_MEM;
                    CLS_BEQ: begin
                        pc_we      = 1'b1;
                        npc_op     = zero ? NPC_BRANCH : NPC_PLUS4;
                        state_next = ST_FETCH;
                    end
                    CLS_R, CLS_I, CLS_LUI, CLS_JAL: state_next = ST_WB;
                    default: state_next = ST_ERR;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_reg == CLS_SW);
                if (mem_ready) begin
                    if (cls_reg == CLS_SW) begin
                        pc_we      = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (wait_last) begin
                    state_next = ST_ERR;
                end
            end
            ST_WB: begin
                reg_we     = 1'b1;
                pc_we      = 1'b1;
                wd_sel     = (cls_reg == CLS_LW)  ? WD_MEM :
                             (cls_reg == CLS_JAL) ? WD_PC  : WD_ALU;
                npc_op     = (cls_reg == CLS_JAL) ? NPC_JUMP : NPC_PLUS4;
                state_next = ST_FETCH;
            end
            ST_ERR:  state_next = ST_ERR;
            default: state_next = ST_ERR;
        endcase
    end

    // Counter restarts whenever FETCH/MEM is (re)entered, counts only while stalled there
    always_comb begin
        wait_cnt_next = '0;
        if ((state_reg == ST_FETCH || state_reg == ST_MEM) && state_next == state_reg)
            wait_cnt_next = wait_cnt_reg + 1'b1;
    end

    assign state = state_reg;
    assign err   = (state_reg == ST_ERR);

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt_reg, instret_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt_reg <= '0;
            instret_reg   <= '0;
        end else begin
            if (state_reg != ST_RST && state_reg != ST_ERR)
                cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (pc_we)
                instret_reg <= instret_reg + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instret   = instret_reg;
`endif

endmodule
